// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                   |
// | Purpose  : Memory-side responder for the icache/dcache request buses.    |
// |            Arbitrates between the two caches and drives a single-ported |
// |            RAM. Dcache bursts of BURST_LEN words are locked, so icache   |
// |            traffic never interleaves inside a block transfer.            |
// | Ports    : CLK, nRST          clock / async active-low reset             |
// |            dREN,dWEN,daddr,dstore -> dload,dwait   dcache side          |
// |            iREN,iaddr             -> iload,iwait   icache side          |
// |            ramREN,ramWEN,ramaddr,ramstore <- ramload,ramstate  RAM side |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int BURST_LEN = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DGRANT  = 2'd1;
  localparam logic [1:0] ST_IGRANT  = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  // Burst length widened to 3 bits so BURST_LEN=4 compares cleanly against
  // the incremented 2-bit counter.
  localparam logic [2:0] BURST_LAST = 3'(BURST_LEN);

  logic [1:0] state_q, state_d;
  logic [1:0] burst_cnt_q, burst_cnt_d;
  logic       last_d_q, last_d_d;

  logic       dreq;
  logic       access;
  logic [2:0] cnt_inc;
  logic       burst_done;

  assign dreq       = dREN | dWEN;
  assign access     = (ramstate == RAM_ACCESS);
  assign cnt_inc    = {1'b0, burst_cnt_q} + 3'd1;
  assign burst_done = (cnt_inc == BURST_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= 2'd0;
      last_d_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_d_q    <= last_d_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    last_d_d    = last_d_q;
    case (state_q)
      ST_IDLE: begin
        // On contention the master that did not go last wins; this is what
        // lets a pending icache read in right after a dcache burst.
        if (dreq && (!iREN || !last_d_q)) begin
          state_d     = ST_DGRANT;
          burst_cnt_d = 2'd0;
        end else if (iREN) begin
          state_d = ST_IGRANT;
        end
      end
      ST_DGRANT: begin
        if (!dreq) begin
          state_d  = ST_IDLE;
          last_d_d = 1'b1;
        end else if (access) begin
          if (burst_done) begin
            state_d  = ST_IDLE;
            last_d_d = 1'b1;
          end else begin
            // Counter only advances while the burst stays locked, so it
            // never exceeds BURST_LEN-1.
            burst_cnt_d = cnt_inc[1:0];
          end
        end
      end
      ST_IGRANT: begin
        if (!iREN) begin
          state_d = ST_IDLE;
        end else if (access) begin
          state_d  = ST_IDLE;
          last_d_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic. Everything is combinational on the registered state, so
  // an asynchronous reset drops the RAM enables the instant state_q clears.
  // --------------------------------------------------------------------------
  always_comb begin
    dwait    = 1'b1;
    iwait    = 1'b1;
    dload    = 32'd0;
    iload    = 32'd0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    case (state_q)
      ST_DGRANT: begin
        // A dropped request leaves the bus quiet for the exit cycle.
        if (dreq) begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (access) begin
            dwait = 1'b0;
            dload = ramload;
          end
        end
      end
      ST_IGRANT: begin
        if (iREN) begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (access) begin
            iwait = 1'b0;
            iload = ramload;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
